// File: rtl/counter_pkg.sv
// counter_pkg: shared direction/mode encodings and width limits for the counter family
package counter_pkg;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam int   MIN_WIDTH = 2;
  localparam int   MAX_WIDTH = 32;
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: emits tick on every PRESCALE-th enabled cycle; clear restarts the phase
module counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] cnt_q, cnt_d;
  assign tick  = enable && cnt_q == PW'(PRESCALE - 1);
  assign cnt_d = clear ? '0 : !enable ? cnt_q : tick ? '0 : cnt_q + PW'(1);
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: up/down counter with runtime max, load, wrap/saturate; COUNTER_PRESCALE_EN adds a step prescaler
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
`ifdef COUNTER_PRESCALE_EN
  , parameter int             PRESCALE    = 4
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] counter_out,
  output logic             wrap_pulse,
  output logic             overflow,
  output logic             at_max,
  output logic             at_zero
`ifdef COUNTER_PRESCALE_EN
  , output logic           prescale_tick
`endif
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic wrap_q, wrap_d, ovf_q, ovf_d, ovf_evt, step;
`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (load),
    .enable (enable),
    .tick   (step)
  );
  assign prescale_tick = step && !load;
`else
  assign step = enable;
`endif
  assign at_max  = cnt_q >= max_value;
  assign at_zero = cnt_q == '0;
  always_comb begin
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    ovf_evt = 1'b0;
    if (load) cnt_d = (load_value > max_value) ? max_value : load_value;
    else if (step && up_down == DIR_UP) begin
      ovf_evt = at_max;
      wrap_d  = at_max && sat_mode == MODE_WRAP;
      cnt_d   = !at_max ? cnt_q + WIDTH'(1) : wrap_d ? '0 : cnt_q;
    end else if (step) begin
      ovf_evt = at_zero;
      wrap_d  = at_zero && sat_mode == MODE_WRAP;
      cnt_d   = !at_zero ? cnt_q - WIDTH'(1) : wrap_d ? max_value : cnt_q;
    end
  end
  // a new overflow event beats a coincident clear
  assign ovf_d = ovf_evt || (ovf_q && !clear_ovf);
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= RESET_VALUE;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end
  assign counter_out = cnt_q;
  assign wrap_pulse  = wrap_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed vector table plus hand sequences for the counter
module tb_param_updown_counter;
  logic clock = 1'b0;
  logic reset, enable, up_down, sat_mode, load, clear_ovf;
  logic [3:0] load_value, max_value, counter_out;
  logic wrap_pulse, overflow, at_max, at_zero;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
`ifdef COUNTER_PRESCALE_EN
  logic ptick;
  param_updown_counter #(.WIDTH(4), .RESET_VALUE(4'd5), .PRESCALE(3)) dut (
`else
  param_updown_counter #(.WIDTH(4), .RESET_VALUE(4'd5)) dut (
`endif
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .sat_mode(sat_mode), .load(load), .load_value(load_value),
    .max_value(max_value), .clear_ovf(clear_ovf), .counter_out(counter_out),
    .wrap_pulse(wrap_pulse), .overflow(overflow), .at_max(at_max), .at_zero(at_zero)
`ifdef COUNTER_PRESCALE_EN
    , .prescale_tick(ptick)
`endif
  );
  typedef struct {
    logic ld, en, up, sat, clr;
    logic [3:0] lv, mx, cnt;
    logic w, o;
  } vec_t;
  vec_t vecs[$];
  task automatic add(input logic ld, en, up, sat, clr, input logic [3:0] lv, mx, cnt,
                     input logic w, o);
    vec_t v;
    v.ld = ld; v.en = en; v.up = up; v.sat = sat; v.clr = clr;
    v.lv = lv; v.mx = mx; v.cnt = cnt; v.w = w; v.o = o;
    vecs.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic ld, en, up, sat, clr, input logic [3:0] lv, mx);
    @(negedge clock);
    load = ld; enable = en; up_down = up; sat_mode = sat; clear_ovf = clr;
    load_value = lv; max_value = mx;
  endtask
  task automatic expect_state(input string tag, input logic [3:0] cnt, input logic [3:0] mx,
                              input logic w, o);
    chk({tag, " cnt"}, 32'(counter_out), 32'(cnt));
    chk({tag, " wrap"}, 32'(wrap_pulse), 32'(w));
    chk({tag, " ovf"}, 32'(overflow), 32'(o));
    chk({tag, " at_max"}, 32'(at_max), 32'(cnt >= mx));
    chk({tag, " at_zero"}, 32'(at_zero), 32'(cnt == 4'd0));
  endtask
  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9);
    @(posedge clock); #1;
    expect_state("reset", 4'd5, 4'd9, 1'b0, 1'b0);
    @(negedge clock); reset = 1'b0;
`ifdef COUNTER_PRESCALE_EN
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
    @(posedge clock); #1;
    expect_state("pre_load", 4'd0, 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
      #1 chk($sformatf("pre_tick%0d", i), 32'(ptick), 32'(i % 3 == 2));
      @(posedge clock); #1;
      chk($sformatf("pre_cnt%0d", i), 32'(counter_out), 32'((i + 1) / 3));
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
    #1 chk("pre_tick_on_load", 32'(ptick), 32'd0);
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
      #1 chk($sformatf("pre_restart_tick%0d", i), 32'(ptick), 32'(i == 2));
      @(posedge clock); #1;
      chk($sformatf("pre_restart_cnt%0d", i), 32'(counter_out), 32'(i == 2));
    end
`else
    add(1, 0, 1, 0, 0, 4'd0, 4'd9, 4'd0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 1, 1, 0, 0, 4'd0, 4'd9, 4'(k), 0, 0);
    add(0, 1, 1, 0, 0, 4'd0, 4'd9, 4'd0, 1, 1);
    add(0, 1, 1, 0, 0, 4'd0, 4'd9, 4'd1, 0, 1);
    add(1, 0, 1, 0, 1, 4'd2, 4'd15, 4'd2, 0, 0);
    add(0, 1, 0, 1, 0, 4'd0, 4'd15, 4'd1, 0, 0);
    add(0, 1, 0, 1, 0, 4'd0, 4'd15, 4'd0, 0, 0);
    add(0, 1, 0, 1, 0, 4'd0, 4'd15, 4'd0, 0, 1);
    add(0, 1, 0, 1, 0, 4'd0, 4'd15, 4'd0, 0, 1);
    add(1, 1, 1, 0, 0, 4'd12, 4'd7, 4'd7, 0, 1);
    add(0, 1, 1, 0, 0, 4'd0, 4'd7, 4'd0, 1, 1);
    add(1, 0, 1, 0, 0, 4'd7, 4'd7, 4'd7, 0, 1);
    add(0, 1, 1, 0, 1, 4'd0, 4'd7, 4'd0, 1, 1);
    add(0, 0, 1, 0, 1, 4'd0, 4'd7, 4'd0, 0, 0);
    add(0, 1, 0, 0, 0, 4'd0, 4'd7, 4'd7, 1, 1);
    add(0, 1, 0, 0, 0, 4'd0, 4'd7, 4'd6, 0, 1);
    add(0, 0, 1, 0, 0, 4'd0, 4'd3, 4'd6, 0, 1);
    add(0, 1, 1, 0, 0, 4'd0, 4'd3, 4'd0, 1, 1);
    add(1, 0, 1, 0, 0, 4'd6, 4'd15, 4'd6, 0, 1);
    add(0, 1, 0, 0, 0, 4'd0, 4'd3, 4'd5, 0, 1);
    add(0, 1, 1, 1, 0, 4'd0, 4'd3, 4'd5, 0, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1);
    add(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1);
    add(0, 1, 0, 1, 1, 4'd0, 4'd0, 4'd0, 0, 1);
    add(0, 0, 1, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0);
    add(1, 0, 1, 0, 0, 4'd15, 4'd15, 4'd15, 0, 0);
    add(0, 1, 1, 0, 0, 4'd0, 4'd15, 4'd0, 1, 1);
    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].sat, vecs[i].clr, vecs[i].lv, vecs[i].mx);
      @(posedge clock); #1;
      expect_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].mx, vecs[i].w, vecs[i].o);
    end
`endif
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd15);
    @(posedge clock); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    @(posedge clock); #1;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    expect_state("midrun_reset", 4'd5, 4'd0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
